data_memory_io: RTL and testbench
=================================

Name: data_memory_io

Overview:
- Data-memory and memory-mapped I/O slave for the 16-bit PMIPS processor.
- Holds a word-organised RAM, a 7-segment display output register and two slide-switch inputs, all behind one address/data port.
- The processor's data-memory address, write-data, write-enable and read-enable drive it; it returns read data combinationally.
- Sits beside the instruction ROM at top level; display and switch ports go to board pins.

Parameters:
- RAM_WORDS, 128, number of 16-bit RAM words; must be a power of 2, at most 32768.
- IO_DISPLAY_ADDR, 16'hFFF0, byte address of the display register.
- IO_SW0_ADDR, 16'hFFF8, byte address of switch 0.
- IO_SW1_ADDR, 16'hFFFA, byte address of switch 1.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rdata  out  16  read data (combinational).
- io_display  out  7  7-segment display register.
- addr  in  16  byte address; bit 0 ignored (word access only).
- wdata  in  16  write data.
- memwrite  in  1  write enable.
- memread  in  1  read enable.
- io_sw0  in  1  slide switch 0.
- io_sw1  in  1  slide switch 1.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Address map, byte addresses with bit 0 ignored:
  - RAM: 0 to 2*RAM_WORDS-1, word index addr[log2(RAM_WORDS):1].
  - Display: IO_DISPLAY_ADDR.
  - Switch 0: IO_SW0_ADDR.
  - Switch 1: IO_SW1_ADDR.
  - All other addresses are unmapped.
- Read path, purely combinational, zero latency:
  - memread=0: rdata=16'h0000.
  - RAM address: RAM word.
  - Switch 0: {15'b0, sw0}; switch 1: {15'b0, sw1}.
  - Display address: {9'b0, io_display}.
  - Unmapped address: 16'h0000.
- Write path, on the rising clock edge when memwrite=1:
  - RAM address: the RAM word takes wdata.
  - Display address: io_display takes wdata[6:0]; wdata[15:7] is discarded.
  - Switch or unmapped address: the write is ignored, with no side effect.
- Read and write to the same address in one cycle: rdata shows the old value until the edge, then the new value.
- memread and memwrite both high is legal; both act independently.
- Reset (reset=0):
  - io_display clears to 7'b0000000 immediately, without waiting for a clock edge.
  - Writes are blocked while reset is low.
  - RAM contents are not cleared; their power-up value is undefined. A bench must write RAM before reading it.
- Reset asserted mid-write: the write is lost for the display register; RAM may or may not be written on that edge.
- Address wrap: RAM never aliases. Addresses at or above 2*RAM_WORDS that are not I/O read 0 and ignore writes.

Optional Feature:
- Macro: SW_SYNC_EN.
- Defined:
  - io_sw0 and io_sw1 each pass through a two-flop synchronizer clocked by clock.
  - The synchronizer flops reset asynchronously to 0.
  - A switch change appears on rdata 2 rising edges later.
- Undefined: the switch inputs feed the read mux directly, with zero latency.

Decomposition:
- Shared package pmips_pkg holds:
  - data width 16 and display width 7;
  - IO_DISPLAY_ADDR, IO_SW0_ADDR and IO_SW1_ADDR defaults;
  - the address-decode enum {SEL_RAM, SEL_DISP, SEL_SW0, SEL_SW1, SEL_NONE}.
- One sub-module, dmem_ram: single-port synchronous-write, asynchronous-read RAM with parameter RAM_WORDS.
- Decode, display register, switch path and read mux live in the top module.

Test Plan:
- RAM round trip: write 16'h1234 to addr 0x0004, then 16'hBEEF to 0x00FE. Read 0x0004 gives 16'h1234; read 0x00FE gives 16'hBEEF; read 0x0005 gives 16'h1234 (bit 0 ignored).
- Display: write 16'hFF5A to 0xFFF0. io_display=7'b1011010 after the edge; reading 0xFFF0 gives 16'h005A.
- Switches: sw0=1, sw1=0. Read 0xFFF8 gives 16'h0001 and 0xFFFA gives 16'h0000. Flip both; reads follow, immediately without SW_SYNC_EN or after 2 edges with it.
- Unmapped and gating:
  - Write 16'hAAAA to 0x1000 (RAM_WORDS=128); RAM words 0x0000 to 0x00FE are unchanged.
  - Read 0x1000 gives 0.
  - Any read with memread=0 gives 0.
- Reset: write display 7'h7F, then pull reset low between edges. io_display=0 immediately. A write during reset is ignored. After release, previously written RAM data still reads back.
- Same-cycle read/write: memread=memwrite=1 at 0x0010 with old value 16'h0001 and wdata 16'h0002. rdata=16'h0001 before the edge and 16'h0002 after.

Source files
------------

// File: rtl/pmips_pkg.sv
// Shared definitions for the PMIPS data-memory / memory-mapped I/O slave:
// datapath widths, default I/O addresses and the address-decode select type.
package pmips_pkg;

  localparam int DATA_W = 16;
  localparam int DISP_W = 7;

  localparam logic [15:0] DEF_IO_DISPLAY_ADDR = 16'hFFF0;
  localparam logic [15:0] DEF_IO_SW0_ADDR     = 16'hFFF8;
  localparam logic [15:0] DEF_IO_SW1_ADDR     = 16'hFFFA;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_DISP,
    SEL_SW0,
    SEL_SW1,
    SEL_NONE
  } sel_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: synchronous write, asynchronous read, no reset.
module dmem_ram
  import pmips_pkg::*;
#(
  parameter int RAM_WORDS = 128,
  parameter int AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_WORDS];

  // Store the write word on the rising edge when enabled
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_memory_io.sv
// Data memory plus memory-mapped I/O for the 16-bit PMIPS core.
// RAM at the bottom of the byte address space, a 7-segment display register
// and two slide switches at the top; reads are combinational.
// Optional macro SW_SYNC_EN adds a two-flop synchronizer on each switch.
module data_memory_io
  import pmips_pkg::*;
#(
  parameter int          RAM_WORDS       = 128,
  parameter logic [15:0] IO_DISPLAY_ADDR = DEF_IO_DISPLAY_ADDR,
  parameter logic [15:0] IO_SW0_ADDR     = DEF_IO_SW0_ADDR,
  parameter logic [15:0] IO_SW1_ADDR     = DEF_IO_SW1_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] rdata,
  output logic [DISP_W-1:0] io_display,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              memwrite,
  input  logic              memread,
  input  logic              io_sw0,
  input  logic              io_sw1
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  sel_e              sel;
  logic              ram_hit;
  logic              ram_we;
  logic              disp_we;
  logic [AW-1:0]     ram_idx;
  logic [DATA_W-1:0] ram_rdata;
  logic [DISP_W-1:0] display_q;
  logic              sw0_v;
  logic              sw1_v;
  logic              unused_addr_lsb;

  // Byte address bit 0 carries no information for word accesses
  assign unused_addr_lsb = addr[0];

  // RAM occupies bytes 0 .. 2*RAM_WORDS-1; no aliasing above that
  assign ram_hit = (({1'b0, addr} >> (AW + 1)) == 17'd0);
  assign ram_idx = addr[AW:1];

  // Address decode; I/O wins so a full 64 KiB RAM still exposes the I/O words
  always_comb begin
    sel = SEL_NONE;
    if (addr[15:1] == IO_DISPLAY_ADDR[15:1])  sel = SEL_DISP;
    else if (addr[15:1] == IO_SW0_ADDR[15:1]) sel = SEL_SW0;
    else if (addr[15:1] == IO_SW1_ADDR[15:1]) sel = SEL_SW1;
    else if (ram_hit)                         sel = SEL_RAM;
  end

  // Writes are blocked while reset is held low
  assign ram_we  = memwrite & reset & (sel == SEL_RAM);
  assign disp_we = memwrite & reset & (sel == SEL_DISP);

  dmem_ram #(
    .RAM_WORDS (RAM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // Display register: async clear, loads the low 7 bits of a display write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       display_q <= '0;
    else if (disp_we) display_q <= wdata[DISP_W-1:0];
  end

  assign io_display = display_q;

`ifdef SW_SYNC_EN
  logic [1:0] sw_p0;
  logic [1:0] sw_p1;

  // Two-flop synchronizer for both switches, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      // stage p0: capture asynchronous pins
      sw_p0 <= {io_sw1, io_sw0};
      // stage p1: settled value seen by the read mux
      sw_p1 <= sw_p0;
    end
  end

  assign sw0_v = sw_p1[0];
  assign sw1_v = sw_p1[1];
`else
  assign sw0_v = io_sw0;
  assign sw1_v = io_sw1;
`endif

  // Combinational read mux; zero when not reading or unmapped
  always_comb begin
    rdata = '0;
    if (memread) begin
      case (sel)
        SEL_RAM:  rdata = ram_rdata;
        SEL_DISP: rdata = {{(DATA_W-DISP_W){1'b0}}, display_q};
        SEL_SW0:  rdata = {{(DATA_W-1){1'b0}}, sw0_v};
        SEL_SW1:  rdata = {{(DATA_W-1){1'b0}}, sw1_v};
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_io.sv
// Self-checking bench for data_memory_io: expected read values are queued
// when a read is driven and popped when rdata is sampled.
module tb_data_memory_io;
  import pmips_pkg::*;

  localparam int RAM_WORDS = 128;

  logic              clock;
  logic              reset;
  logic [15:0]       rdata;
  logic [6:0]        io_display;
  logic [15:0]       addr;
  logic [15:0]       wdata;
  logic              memwrite;
  logic              memread;
  logic              io_sw0;
  logic              io_sw1;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model [RAM_WORDS];
  int          n_vec;
  int          n_miss;

  data_memory_io #(
    .RAM_WORDS       (RAM_WORDS),
    .IO_DISPLAY_ADDR (16'hFFF0),
    .IO_SW0_ADDR     (16'hFFF8),
    .IO_SW1_ADDR     (16'hFFFA)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rdata      (rdata),
    .io_display (io_display),
    .addr       (addr),
    .wdata      (wdata),
    .memwrite   (memwrite),
    .memread    (memread),
    .io_sw0     (io_sw0),
    .io_sw1     (io_sw1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: one write cycle, ends at the following negedge
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr     = a;
    wdata    = d;
    memwrite = 1'b1;
    memread  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    memwrite = 1'b0;
  endtask

  // Drive a read, queue the expectation, sample 1 time unit later
  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    exp_t e;
    addr    = a;
    memread = 1'b1;
    sb_q.push_back('{tag, exp});
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, rdata, e.exp);
  endtask

  task automatic wr_ram(input logic [15:0] a, input logic [15:0] d);
    wr(a, d);
    model[a[7:1]] = d;
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    reset    = 1'b1;
    addr     = '0;
    wdata    = '0;
    memwrite = 1'b0;
    memread  = 1'b0;
    io_sw0   = 1'b0;
    io_sw1   = 1'b0;
    #2 reset = 1'b0;
    #1 check_eq("reset_display", {9'b0, io_display}, 16'h0000);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Fill RAM with a known pattern
    for (int i = 0; i < RAM_WORDS; i++) begin
      logic [15:0] a;
      a = 16'(i * 2);
      wr_ram(a, 16'(i * 16'h0101) ^ 16'h5A5A);
    end

    // RAM round trip, bit 0 ignored
    wr_ram(16'h0004, 16'h1234);
    wr_ram(16'h00FE, 16'hBEEF);
    rd("ram_0004", 16'h0004, 16'h1234);
    rd("ram_00FE", 16'h00FE, 16'hBEEF);
    rd("ram_0005", 16'h0005, 16'h1234);

    // Unmapped and switch writes must not touch anything
    wr(16'h1000, 16'hAAAA);
    wr(16'h0100, 16'hAAAA);
    wr(16'hFFFE, 16'hAAAA);
    wr(16'hFFF8, 16'hAAAA);
    for (int i = 0; i < RAM_WORDS; i++) begin
      logic [15:0] a;
      a = 16'(i * 2);
      rd($sformatf("ram_keep_%0h", a), a, model[i]);
    end
    rd("unmapped_1000", 16'h1000, 16'h0000);
    rd("unmapped_0100", 16'h0100, 16'h0000);
    rd("unmapped_FFFE", 16'hFFFE, 16'h0000);
    check_eq("display_untouched", {9'b0, io_display}, 16'h0000);

    // memread low gates everything to zero
    addr    = 16'h0004;
    memread = 1'b0;
    #1 check_eq("memread_low", rdata, 16'h0000);

    // Display register
    @(negedge clock);
    wr(16'hFFF0, 16'hFF5A);
    check_eq("display_val", {9'b0, io_display}, 16'h005A);
    rd("display_rd", 16'hFFF0, 16'h005A);
    rd("display_rd_odd", 16'hFFF1, 16'h005A);

    // Switches
    @(negedge clock);
    io_sw0 = 1'b1;
    io_sw1 = 1'b0;
    repeat (3) @(negedge clock);
    rd("sw0_hi", 16'hFFF8, 16'h0001);
    rd("sw1_lo", 16'hFFFA, 16'h0000);
    @(negedge clock);
    io_sw0 = 1'b0;
    io_sw1 = 1'b1;
`ifdef SW_SYNC_EN
    @(negedge clock);
    rd("sw0_lag1", 16'hFFF8, 16'h0001);
    rd("sw1_lag1", 16'hFFFA, 16'h0000);
    @(negedge clock);
`endif
    rd("sw0_flip", 16'hFFF8, 16'h0000);
    rd("sw1_flip", 16'hFFFA, 16'h0001);

    // Same-cycle read and write
    @(negedge clock);
    wr_ram(16'h0010, 16'h0001);
    addr     = 16'h0010;
    wdata    = 16'h0002;
    memread  = 1'b1;
    memwrite = 1'b1;
    #1 check_eq("rw_before", rdata, 16'h0001);
    @(posedge clock);
    #1 check_eq("rw_after", rdata, 16'h0002);
    model[8] = 16'h0002;
    @(negedge clock);
    memwrite = 1'b0;

    // Reset behaviour
    wr(16'hFFF0, 16'h007F);
    check_eq("display_7f", {9'b0, io_display}, 16'h007F);
    #2 reset = 1'b0;
    #1 check_eq("reset_async_clear", {9'b0, io_display}, 16'h0000);
    @(negedge clock);
    wr(16'hFFF0, 16'h0055);
    check_eq("reset_disp_blocked", {9'b0, io_display}, 16'h0000);
    wr(16'h0020, 16'hDEAD);
    reset = 1'b1;
    @(negedge clock);
    check_eq("post_reset_display", {9'b0, io_display}, 16'h0000);
    rd("post_reset_ram_0004", 16'h0004, 16'h1234);
    rd("post_reset_ram_0010", 16'h0010, 16'h0002);
    rd("reset_ram_blocked", 16'h0020, model[16]);

    check_eq("sb_empty", 16'(sb_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
